// File: rtl/fp_addsub_pkg.sv
// Shared FP32 field positions, result flag indices and FIFO occupancy encoding
// for the adder/subtractor result stage.
package fp_addsub_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    localparam int FLG_NAN    = 3;
    localparam int FLG_INF    = 2;
    localparam int FLG_ZERO   = 1;
    localparam int FLG_DENORM = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

endpackage

// File: rtl/fp_result_classify.sv
// Combinational FP32 result classifier producing {nan,inf,zero,denorm};
// with FP_RESULT_FTZ_EN defined, denormals are flushed to a signed zero.
module fp_result_classify
    import fp_addsub_pkg::*;
(
    input  logic [31:0] in_result,
    output logic [31:0] out_result,
    output logic [3:0]  flags
);

    logic [7:0]        exp_field;
    logic [MANT_W-1:0] mant_field;
    logic              exp_max;
    logic              exp_zero;
    logic              mant_zero;

    assign exp_field  = in_result[EXP_MSB:EXP_LSB];
    assign mant_field = in_result[MANT_W-1:0];
    assign exp_max    = (exp_field == EXP_MAX);
    assign exp_zero   = (exp_field == 8'h00);
    assign mant_zero  = (mant_field == '0);

    always_comb begin
        out_result         = in_result;
        flags              = '0;
        flags[FLG_NAN]     = exp_max & ~mant_zero;
        flags[FLG_INF]     = exp_max & mant_zero;
        flags[FLG_ZERO]    = exp_zero & mant_zero;
        flags[FLG_DENORM]  = exp_zero & ~mant_zero;
`ifdef FP_RESULT_FTZ_EN
        // Flushed denormals keep their sign and report as zero.
        if (exp_zero && !mant_zero) begin
            out_result        = {in_result[SIGN_BIT], 31'b0};
            flags[FLG_ZERO]   = 1'b1;
            flags[FLG_DENORM] = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/fp_addsub_result_stage.sv
// Registered output FIFO for FP32 adder results with classification flags,
// sticky status and a delivered-result counter. Optional FTZ: FP_RESULT_FTZ_EN.
module fp_addsub_result_stage
    import fp_addsub_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags,
    output logic [3:0]       sticky_flags,
    input  logic             flags_clr,
    output logic [CNT_W-1:0] result_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + TAG_W + 4;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [OCC_W-1:0]   occ_reg;
    logic [OCC_W-1:0]   occ_next;
    occ_state_e         state_reg;
    occ_state_e         state_next;
    logic [3:0]         sticky_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [31:0]        cls_result;
    logic [3:0]         cls_flags;
    logic               push;
    logic               pop;

    fp_result_classify u_classify (
        .in_result  (in_result),
        .out_result (cls_result),
        .flags      (cls_flags)
    );

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= OCC_EMPTY;
            occ_reg   <= '0;
        end else begin
            state_reg <= state_next;
            occ_reg   <= occ_next;
        end
    end

    always_comb begin
        occ_next   = occ_reg;
        state_next = state_reg;
        if (push && !pop)
            occ_next = occ_reg + OCC_W'(1);
        else if (pop && !push)
            occ_next = occ_reg - OCC_W'(1);
        case (state_reg)
            OCC_EMPTY:   if (push) state_next = OCC_PARTIAL;
            OCC_PARTIAL: begin
                if (push && !pop && occ_next == OCC_MAX)
                    state_next = OCC_FULL;
                else if (pop && !push && occ_next == '0)
                    state_next = OCC_EMPTY;
            end
            OCC_FULL:    if (pop) state_next = OCC_PARTIAL;
            default:     state_next = OCC_EMPTY;
        endcase
    end

    // No bypass when full: a pop frees the slot only for the following cycle.
    always_comb begin
        in_ready  = (state_reg != OCC_FULL);
        out_valid = (state_reg != OCC_EMPTY);
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    mem_reg[gi] <= '0;
                else if (push && wr_ptr_reg == PTR_W'(gi))
                    mem_reg[gi] <= {cls_result, in_tag, cls_flags};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            sticky_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                count_reg  <= count_reg + CNT_W'(1);
            end
            // A clear coinciding with a push keeps only the new entry's flags.
            if (push)
                sticky_reg <= flags_clr ? cls_flags : (sticky_reg | cls_flags);
            else if (flags_clr)
                sticky_reg <= '0;
        end
    end

    assign {out_result, out_tag, out_flags} = mem_reg[rd_ptr_reg];
    assign sticky_flags = sticky_reg;
    assign result_count = count_reg;

endmodule
